prog_store: RTL and testbench

- Writable, synchronous program memory; successor to the fixed asynchronous program ROM.
- The CPU fetch stage reads instruction words with one-cycle latency.
- A byte-wide loader port fills memory at run time with no resynthesis.
- After reset, a clear sweep zeroes every word, so unloaded locations fetch as NOP.

---
 rtl/prog_store_pkg.sv | 23 ++
 rtl/prog_store_ram.sv | 36 +++
 rtl/prog_store.sv | 216 +++++++++++++++++++++
 tb/tb_prog_store.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_store_pkg.sv
// Purpose: shared types and helpers for the writable program store.
// Latency: n/a (types, constants and a sizing function only).
// Backpressure: n/a.
package prog_store_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // NOP instruction is all zeros; wide enough to be sliced to any word width.
    localparam int                  NOP_MAX_W = 128;
    localparam logic [NOP_MAX_W-1:0] NOP_WORD = '0;

    // Loader bytes per instruction word: ceil(instr_w / byte_w).
    function automatic int calc_bpw(input int instr_w, input int byte_w);
        return (instr_w + byte_w - 1) / byte_w;
    endfunction

endpackage

// File: rtl/prog_store_ram.sv
// Purpose: single-port synchronous RAM array, one write port, registered read.
// Latency: write commits at the clock edge; read data one cycle after re.
// Backpressure: none; the caller never asserts we and re together.
module prog_store_ram #(
    parameter int WORD_W = 35,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage array: no reset, the controller clears it by sweeping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/prog_store.sv
// Purpose: writable program memory with clear sweep, byte loader and fetch port (parity via PROG_STORE_PARITY_EN).
// Latency: fetch data one cycle after fetch_en; a word is written on its last loader byte.
// Backpressure: ld_ready only in LOAD; fetches while busy are dropped and must be re-issued.
module prog_store
    import prog_store_pkg::*;
#(
    parameter int INSTR_W = 35,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int BYTE_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] fetch_data,
    output logic               fetch_valid,
    output logic               busy,
    input  logic               ld_start,
    input  logic [ADDR_W-1:0]  ld_base,
    input  logic [ADDR_W-1:0]  ld_count,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [BYTE_W-1:0]  ld_byte,
    output logic               ld_done,
    output logic               err
);

    localparam int BPW   = calc_bpw(INSTR_W, BYTE_W);
    localparam int ASM_W = BPW * BYTE_W;
    localparam int KW    = (BPW > 1) ? $clog2(BPW) : 1;
`ifdef PROG_STORE_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [ADDR_W-1:0]   rem_q;
    logic [KW-1:0]       k_q;
    logic [ASM_W-1:0]    asm_q, asm_next;
    logic                err_q;
    logic                fetch_valid_q;
    logic                oor_q;

    logic                ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [INSTR_W-1:0]  wr_word;
    logic [MEM_W-1:0]    ram_wdata, ram_rdata;
    logic                accept_start, range_bad, fetch_in_range;
    logic                beat, last_byte, par_bad;

    assign accept_start   = (state_q == ST_IDLE) && ld_start;
    assign range_bad      = ({1'b0, ld_base} + {1'b0, ld_count}) > DEPTH_X;
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
    assign beat           = (state_q == ST_LOAD) && ld_valid;
    assign last_byte      = (k_q == KW'(BPW - 1));

    // Byte assembler: drop the incoming byte into slot k.
    always_comb begin
        asm_next = asm_q;
        for (int b = 0; b < BPW; b++) begin
            if (k_q == KW'(b)) begin
                asm_next[b*BYTE_W +: BYTE_W] = ld_byte;
            end
        end
    end

    // Next-state and RAM port control; memory is only read in IDLE and only written in CLEAR/LOAD.
    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = fetch_addr;
        wr_word  = NOP_WORD[INSTR_W-1:0];
        case (state_q)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_addr_q;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ram_re = fetch_en && fetch_in_range;
                if (ld_start) begin
                    if ((ld_count == '0) || range_bad) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (beat && last_byte) begin
                    ram_we   = 1'b1;
                    ram_addr = wr_addr_q;
                    wr_word  = asm_next[INSTR_W-1:0];
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef PROG_STORE_PARITY_EN
    // Even parity: stored bit makes the XOR of the whole stored word zero.
    assign ram_wdata = {^wr_word, wr_word};
    assign par_bad   = ^ram_rdata;
`else
    assign ram_wdata = wr_word;
    assign par_bad   = 1'b0;
`endif

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear sweep address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
        end
    end

    // Loader bookkeeping: write address, words remaining, byte slot and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rem_q     <= '0;
            k_q       <= '0;
            asm_q     <= '0;
        end else if (accept_start) begin
            wr_addr_q <= ld_base;
            rem_q     <= ld_count;
            k_q       <= '0;
            asm_q     <= '0;
        end else if (beat) begin
            asm_q <= asm_next;
            if (last_byte) begin
                k_q       <= '0;
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
                rem_q     <= rem_q - ADDR_W'(1);
            end else begin
                k_q <= k_q + KW'(1);
            end
        end
    end

    // Sticky error: a new load clears it, later set conditions in this block win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            if (accept_start) begin
                err_q <= range_bad && (ld_count != '0);
            end
            if (ld_start && (state_q != ST_IDLE)) begin
                err_q <= 1'b1;
            end
            if (fetch_valid_q && !oor_q && par_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // Fetch response tracking; out-of-range flag only updates on an accepted fetch so data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            oor_q         <= 1'b0;
        end else begin
            fetch_valid_q <= (state_q == ST_IDLE) && fetch_en;
            if ((state_q == ST_IDLE) && fetch_en) begin
                oor_q <= !fetch_in_range;
            end
        end
    end

    prog_store_ram #(
        .WORD_W (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign fetch_data  = (oor_q || par_bad) ? NOP_WORD[INSTR_W-1:0] : ram_rdata[INSTR_W-1:0];
    assign fetch_valid = fetch_valid_q;
    // Gated by rst_n so busy reads 0 while reset is held, even though the FSM sits in CLEAR.
    assign busy        = rst_n && ((state_q == ST_CLEAR) || (state_q == ST_LOAD));
    assign ld_ready    = (state_q == ST_LOAD);
    assign ld_done     = (state_q == ST_DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_prog_store.sv
module tb_prog_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  fetch_addr;
    logic [34:0] fetch_data;
    logic        fetch_valid;
    logic        busy;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic [7:0]  ld_count;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_done;
    logic        err;

    // Second instance with a non-power-of-two depth, loader idle.
    logic        fetch_en2;
    logic [7:0]  fetch_addr2;
    logic [34:0] fetch_data2;
    logic        fetch_valid2;
    logic        busy2;
    logic        ld_start2;
    logic [7:0]  ld_base2;
    logic [7:0]  ld_count2;
    logic        ld_valid2;
    logic        ld_ready2;
    logic [7:0]  ld_byte2;
    logic        ld_done2;
    logic        err2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [34:0] exp_q[$];
    logic [34:0] exp2_q[$];

    always #5 clk = ~clk;

    prog_store dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid), .busy(busy),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte),
        .ld_done(ld_done), .err(err)
    );

    prog_store #(.DEPTH(200)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en2), .fetch_addr(fetch_addr2),
        .fetch_data(fetch_data2), .fetch_valid(fetch_valid2), .busy(busy2),
        .ld_start(ld_start2), .ld_base(ld_base2), .ld_count(ld_count2),
        .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_byte(ld_byte2),
        .ld_done(ld_done2), .err(err2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every fetch_valid pops one expected word.
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (exp_q.size() == 0) check("unexpected_fetch_valid", 64'(fetch_valid), 64'd0);
            else check("fetch_data", 64'(fetch_data), 64'(exp_q.pop_front()));
        end
        if (ld_done) done_cnt++;
    end

    always @(negedge clk) begin
        if (fetch_valid2) begin
            if (exp2_q.size() == 0) check("unexpected_fetch_valid_small", 64'(fetch_valid2), 64'd0);
            else check("fetch_data_small", 64'(fetch_data2), 64'(exp2_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] addr, input logic [34:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        exp_q.push_back(exp);
        step();
        fetch_en = 1'b0;
        step();
    endtask

    task automatic fetch_small(input logic [7:0] addr, input logic [34:0] exp);
        fetch_en2   = 1'b1;
        fetch_addr2 = addr;
        exp2_q.push_back(exp);
        step();
        fetch_en2 = 1'b0;
        step();
    endtask

    task automatic start_load(input logic [7:0] base, input logic [7:0] count);
        ld_start = 1'b1;
        ld_base  = base;
        ld_count = count;
        step();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  t;
        logic ok;
        repeat (gap) step();
        ld_valid = 1'b1;
        ld_byte  = b;
        t = 0;
        do begin
            ok = ld_ready;
            step();
            t++;
        end while (!ok && t < 50);
        ld_valid = 1'b0;
        if (!ok) check("ld_ready_timeout", 64'(ld_ready), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 1000) begin
            step();
            t++;
        end
        if (t >= 1000) check(name, 64'(busy), 64'd0);
    endtask

    task automatic check_done(input string name);
        repeat (2) step();
        check(name, 64'(done_cnt), 64'(exp_done));
    endtask

    int          clr_cycles;
    int          gaps [10] = '{0, 2, 1, 0, 3, 0, 0, 1, 2, 0};
    logic [7:0]  w30_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h7F};

    initial begin
        rst_n = 1'b0;
        fetch_en = 1'b0; fetch_addr = '0;
        ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_valid = 1'b0; ld_byte = '0;
        fetch_en2 = 1'b0; fetch_addr2 = '0;
        ld_start2 = 1'b0; ld_base2 = '0; ld_count2 = '0; ld_valid2 = 1'b0; ld_byte2 = '0;
        repeat (3) step();

        // Outputs held at zero during reset.
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_fetch_data", 64'(fetch_data), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        check("rst_ld_done", 64'(ld_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // Clear sweep lasts exactly DEPTH cycles.
        rst_n = 1'b1;
        clr_cycles = 0;
        @(negedge clk);
        while (busy && clr_cycles < 1000) begin
            clr_cycles++;
            @(negedge clk);
        end
        check("clear_cycles", 64'(clr_cycles), 64'd256);
        step();

        fetch(8'd0, 35'h0);
        fetch(8'd17, 35'h0);
        fetch(8'd255, 35'h0);
        fetch_small(8'd255, 35'h0);
        fetch_small(8'd199, 35'h0);

        // Two-word load with stalls; a fetch during LOAD is dropped.
        start_load(8'd4, 8'd2);
        check("busy_in_load", 64'(busy), 64'd1);
        fetch_en = 1'b1; fetch_addr = 8'd4;
        step();
        fetch_en = 1'b0;
        check("fetch_valid_while_busy", 64'(fetch_valid), 64'd0);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1), gaps[i]);
        exp_done++;
        check_done("ld_done_load2");
        check("err_after_good_load", 64'(err), 64'd0);
        fetch(8'd4, 35'h504030201);
        fetch(8'd5, 35'h209080706);

        // Range overflow: error, done pulse, nothing written.
        start_load(8'd250, 8'd10);
        check("err_range", 64'(err), 64'd1);
        exp_done++;
        check_done("ld_done_range");
        fetch(8'd250, 35'h0);
        fetch(8'd255, 35'h0);
        check("err_sticky", 64'(err), 64'd1);
        start_load(8'd0, 8'd0);
        check("err_cleared_count0", 64'(err), 64'd0);
        exp_done++;
        check_done("ld_done_count0");

        // Same-cycle fetch and load start; then a stray ld_start during LOAD.
        fetch_en = 1'b1; fetch_addr = 8'd5;
        exp_q.push_back(35'h209080706);
        ld_start = 1'b1; ld_base = 8'd30; ld_count = 8'd1;
        step();
        fetch_en = 1'b0; ld_start = 1'b0;
        check("busy_after_same_cycle_start", 64'(busy), 64'd1);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("err_start_in_load", 64'(err), 64'd1);
        for (int i = 0; i < 5; i++) send_byte(w30_bytes[i], 0);
        exp_done++;
        check_done("ld_done_word30");
        fetch(8'd30, 35'h744332211);

`ifdef PROG_STORE_PARITY_EN
        start_load(8'd0, 8'd0);
        exp_done++;
        check_done("ld_done_par_clear");
        check("err_before_parity", 64'(err), 64'd0);
        dut.u_ram.mem[4] = dut.u_ram.mem[4] ^ 36'h8;
        fetch(8'd4, 35'h0);
        check("err_parity", 64'(err), 64'd1);
        fetch(8'd5, 35'h209080706);
        check("err_parity_sticky", 64'(err), 64'd1);
        start_load(8'd0, 8'd0);
        check("err_parity_cleared", 64'(err), 64'd0);
        exp_done++;
        check_done("ld_done_par_end");
`endif

        // Reset partway through a word: clear reruns and nothing of the partial word lands.
        start_load(8'd4, 8'd1);
        for (int i = 0; i < 3; i++) send_byte(8'hF0 + 8'(i), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("busy_after_mid_reset", 64'(busy), 64'd1);
        wait_idle("mid_reset_clear_timeout");
        check("done_after_mid_reset", 64'(done_cnt), 64'(exp_done));
        fetch(8'd4, 35'h0);
        fetch(8'd5, 35'h0);
        fetch(8'd30, 35'h0);

        repeat (3) step();
        check("fetch_queue_empty", 64'(exp_q.size()), 64'd0);
        check("fetch_queue_empty_small", 64'(exp2_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
